// File: rtl/score_board_pkg.sv
// Shared types for the dual-issue scoreboard: forwarding-source codes,
// per-lane stage entries and the stage/lane to code mapping.
package score_board_pkg;

    localparam int LANES      = 2;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_SRC    = 4;
    localparam int SB_STAGES  = 3;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [2:0] {
        SB_REGFILE = 3'd0,
        SB_EX0     = 3'd1,
        SB_EX1     = 3'd2,
        SB_MEM0    = 3'd3,
        SB_MEM1    = 3'd4,
        SB_CMT0    = 3'd5,
        SB_CMT1    = 3'd6,
        SB_WAIT    = 3'd7
    } sb_src_e;

    typedef sb_src_e score_board_data_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t waddr;
        logic      is_load;
    } sb_entry_t;

    // One pipeline row holds one entry per issue lane.
    typedef sb_entry_t [LANES-1:0] sb_row_t;

    // Stage 0 = EX, 1 = MEM, 2 = CMT; codes run EX0, EX1, MEM0, ... upward.
    function automatic sb_src_e stage_code(input int stage, input int lane);
        return sb_src_e'(3'(1 + 2 * stage + lane));
    endfunction

endpackage

// File: rtl/score_board_if.sv
// Issue-side query/update bundle between issue, bypass and the scoreboard.
interface score_board_if;
    import score_board_pkg::*;

    logic [LANES-1:0]                   issue_valid;
    logic [LANES-1:0]                   issue_wen;
    logic [LANES-1:0][REG_ADDR_W-1:0]   issue_waddr;
    logic [LANES-1:0]                   issue_is_load;
    logic                               flush;
    logic [NUM_SRC-1:0][REG_ADDR_W-1:0] src_addr;
    logic [NUM_SRC-1:0][2:0]            score_board_data;
    logic [NUM_SRC-1:0]                 src_wait;
    logic                               pair_conflict;

    modport master (
        output issue_valid, issue_wen, issue_waddr, issue_is_load, flush, src_addr,
        input  score_board_data, src_wait, pair_conflict
    );

    modport slave (
        input  issue_valid, issue_wen, issue_waddr, issue_is_load, flush, src_addr,
        output score_board_data, src_wait, pair_conflict
    );

endinterface

// File: rtl/score_board_lookup.sv
// Youngest-first priority match of one source register against the
// EX/MEM/CMT rows; loads still in EX report WAIT.
module sb_lookup
    import score_board_pkg::*;
(
    input  reg_addr_t                 src_addr,
    input  sb_row_t [SB_STAGES-1:0]   rows,
    output sb_src_e                   code
);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        code = SB_REGFILE;
        // Scan oldest to youngest so the last (youngest) hit overwrites.
        for (int s = SB_STAGES - 1; s >= 0; s--) begin
            for (int l = 0; l < LANES; l++) begin
                if (rows[s][l].valid && rows[s][l].waddr == src_addr) begin
                    code = (s == 0 && rows[s][l].is_load) ? SB_WAIT : stage_code(s, l);
                end
            end
        end
        if (src_addr == '0) begin
            code = SB_REGFILE;
        end
    end

endmodule

// File: rtl/score_board.sv
// In-flight destination tracker for the dual-issue pipeline: shifts issue
// destinations through EX/MEM/CMT and reports a forwarding source per operand.
module score_board
    import score_board_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    score_board_if.slave      sb
);

    sb_row_t [SB_STAGES-1:0] rows_q;
    sb_row_t [SB_STAGES-1:0] rows_d;
    sb_src_e                 code [NUM_SRC];

    always_comb begin
        rows_d    = rows_q;
        rows_d[2] = rows_q[1];
        // A flush kills EX and the EX-to-MEM move; CMT still advances.
        rows_d[1] = sb.flush ? '0 : rows_q[0];
        for (int k = 0; k < LANES; k++) begin
            rows_d[0][k].valid   = sb.issue_valid[k] & sb.issue_wen[k] &
                                   (sb.issue_waddr[k] != '0) & ~sb.flush;
            rows_d[0][k].waddr   = sb.issue_waddr[k];
            rows_d[0][k].is_load = sb.issue_is_load[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignment so every row samples the pre-edge values of the others.
        if (rst) begin
            rows_q <= '0;
        end else begin
            rows_q <= rows_d;
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_lookup
        sb_lookup u_lookup (
            .src_addr (sb.src_addr[g]),
            .rows     (rows_q),
            .code     (code[g])
        );
        assign sb.score_board_data[g] = code[g];
        assign sb.src_wait[g]         = (code[g] == SB_WAIT);
    end

    // Lane1 may not read what lane0 writes in the same issue group.
    assign sb.pair_conflict = sb.issue_valid[0] & sb.issue_wen[0] &
                              (sb.issue_waddr[0] != '0) &
                              ((sb.src_addr[2] == sb.issue_waddr[0]) |
                               (sb.src_addr[3] == sb.issue_waddr[0]));

endmodule

// File: tb/tb_score_board.sv
// Directed bench for score_board: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_score_board;
    import score_board_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    score_board_if sbi ();

    score_board dut (
        .clk (clk),
        .rst (rst),
        .sb  (sbi)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [11:0] codes;
        logic        conflict;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Codes listed as src3, src2, src1, src0.
    task automatic expect_now(input string name, input int c3, input int c2,
                              input int c1, input int c0, input logic conflict);
        exp_t e;
        e.name     = name;
        e.codes    = {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
        e.conflict = conflict;
        q.push_back(e);
    endtask

    task automatic set_issue(input logic [1:0] v, input logic [1:0] wen, input int w0,
                             input int w1, input logic [1:0] ld, input logic fl);
        sbi.issue_valid   = v;
        sbi.issue_wen     = wen;
        sbi.issue_waddr   = {5'(w1), 5'(w0)};
        sbi.issue_is_load = ld;
        sbi.flush         = fl;
    endtask

    task automatic idle();
        set_issue(2'b00, 2'b00, 0, 0, 2'b00, 1'b0);
    endtask

    task automatic set_src(input int a3, input int a2, input int a1, input int a0);
        sbi.src_addr = {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t        e;
        logic [3:0]  wait_exp;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                for (int i = 0; i < NUM_SRC; i++) begin
                    wait_exp[i] = (e.codes[i*3 +: 3] == 3'd7);
                end
                check({e.name, ".codes"}, 32'(sbi.score_board_data), 32'(e.codes));
                check({e.name, ".wait"}, 32'(sbi.src_wait), 32'(wait_exp));
                check({e.name, ".conflict"}, 32'(sbi.pair_conflict), 32'(e.conflict));
            end
        end
    end

    initial begin : stimulus
        idle();
        set_src(4, 3, 2, 1);
        #1;
        expect_now("reset_idle", 0, 0, 0, 0, 1'b0);
        tick();
        set_issue(2'b01, 2'b01, 1, 0, 2'b00, 1'b0);
        expect_now("reset_hold", 0, 0, 0, 0, 1'b0);
        tick();
        rst = 1'b0;
        idle();
        expect_now("reset_release", 0, 0, 0, 0, 1'b0);
        tick();

        // ALU destination walks EX0 -> MEM0 -> CMT0 -> regfile.
        set_issue(2'b01, 2'b01, 5, 0, 2'b00, 1'b0);
        set_src(0, 5, 0, 5);
        expect_now("alu_issue", 0, 0, 0, 0, 1'b1);
        tick(); idle();
        expect_now("alu_ex0", 0, 1, 0, 1, 1'b0);
        tick();
        expect_now("alu_mem0", 0, 3, 0, 3, 1'b0);
        tick();
        expect_now("alu_cmt0", 0, 5, 0, 5, 1'b0);
        tick();
        expect_now("alu_regfile", 0, 0, 0, 0, 1'b0);
        tick();

        // Load waits one cycle in EX.
        set_issue(2'b01, 2'b01, 7, 0, 2'b01, 1'b0);
        set_src(7, 0, 0, 7);
        expect_now("load_issue", 0, 0, 0, 0, 1'b1);
        tick(); idle();
        expect_now("load_wait", 7, 0, 0, 7, 1'b0);
        tick();
        expect_now("load_mem0", 3, 0, 0, 3, 1'b0);
        tick();
        expect_now("load_cmt0", 5, 0, 0, 5, 1'b0);
        tick();
        expect_now("load_regfile", 0, 0, 0, 0, 1'b0);
        tick();

        // Same destination in both lanes, then a younger lane0 writer.
        set_issue(2'b11, 2'b11, 9, 9, 2'b00, 1'b0);
        set_src(0, 0, 0, 9);
        expect_now("dual_issue", 0, 0, 0, 0, 1'b0);
        tick();
        set_issue(2'b01, 2'b01, 9, 0, 2'b00, 1'b0);
        expect_now("dual_ex1", 0, 0, 0, 2, 1'b0);
        tick(); idle();
        expect_now("ex0_over_mem1", 0, 0, 0, 1, 1'b0);
        tick();
        expect_now("dual_mem0", 0, 0, 0, 3, 1'b0);
        tick();
        expect_now("dual_cmt0", 0, 0, 0, 5, 1'b0);
        tick();
        expect_now("dual_regfile", 0, 0, 0, 0, 1'b0);
        tick();

        // Pair conflict and lane1 stage codes.
        set_issue(2'b01, 2'b01, 3, 0, 2'b00, 1'b0);
        set_src(3, 0, 0, 0);
        expect_now("conflict_hit", 0, 0, 0, 0, 1'b1);
        tick();
        set_issue(2'b01, 2'b01, 3, 0, 2'b00, 1'b0);
        set_src(0, 0, 0, 3);
        expect_now("conflict_clear", 0, 0, 0, 1, 1'b0);
        tick();
        set_issue(2'b10, 2'b10, 3, 3, 2'b00, 1'b0);
        set_src(3, 0, 0, 0);
        expect_now("lane1_dest_no_conflict", 1, 0, 0, 0, 1'b0);
        tick(); idle();
        set_src(0, 0, 0, 3);
        expect_now("lane1_ex1", 0, 0, 0, 2, 1'b0);
        tick();
        expect_now("lane1_mem1", 0, 0, 0, 4, 1'b0);
        tick();
        expect_now("lane1_cmt1", 0, 0, 0, 6, 1'b0);
        tick();
        expect_now("lane1_regfile", 0, 0, 0, 0, 1'b0);
        tick();

        // Register zero and wen=0 are never tracked.
        set_issue(2'b01, 2'b01, 0, 0, 2'b00, 1'b0);
        set_src(0, 0, 0, 0);
        expect_now("zero_dest_no_conflict", 0, 0, 0, 0, 1'b0);
        tick();
        set_issue(2'b01, 2'b00, 8, 0, 2'b00, 1'b0);
        expect_now("zero_src_regfile", 0, 0, 0, 0, 1'b0);
        tick(); idle();
        set_src(0, 0, 0, 8);
        expect_now("wen0_not_tracked", 0, 0, 0, 0, 1'b0);
        tick();

        // Flush at the issue edge, then flush with EX and MEM occupied.
        set_issue(2'b01, 2'b01, 6, 0, 2'b00, 1'b1);
        set_src(0, 0, 0, 6);
        expect_now("flush_same_edge", 0, 0, 0, 0, 1'b0);
        tick();
        set_issue(2'b01, 2'b01, 10, 0, 2'b00, 1'b0);
        expect_now("flush_dropped", 0, 0, 0, 0, 1'b0);
        tick();
        set_issue(2'b01, 2'b01, 6, 0, 2'b00, 1'b0);
        set_src(0, 10, 0, 6);
        expect_now("flush_pre", 0, 1, 0, 0, 1'b0);
        tick();
        set_issue(2'b00, 2'b00, 0, 0, 2'b00, 1'b1);
        expect_now("flush_edge", 0, 3, 0, 1, 1'b0);
        tick(); idle();
        expect_now("flush_after", 0, 5, 0, 0, 1'b0);
        tick();
        expect_now("flush_drain", 0, 0, 0, 0, 1'b0);
        tick();

        // Asynchronous reset in the middle of traffic.
        set_issue(2'b01, 2'b01, 11, 0, 2'b00, 1'b0);
        set_src(0, 0, 0, 11);
        expect_now("rst_pre", 0, 0, 0, 0, 1'b0);
        tick();
        set_issue(2'b01, 2'b01, 12, 0, 2'b00, 1'b0);
        set_src(0, 12, 0, 11);
        expect_now("rst_traffic", 0, 0, 0, 1, 1'b1);
        tick(); idle();
        rst = 1'b1;
        expect_now("rst_async", 0, 0, 0, 0, 1'b0);
        tick();
        rst = 1'b0;
        expect_now("rst_done", 0, 0, 0, 0, 1'b0);
        tick();
        tick();

        check("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
